wb_port_arbiter: RTL and testbench

Arbiter and sequencer for the register-file write port at the writeback stage. Shares the single 32-bit write port between two requesters: the in-order pipeline writeback, i.e. the output of the ALU/load select mux, and a long-latency unit (multiply/divide) that completes out of band. The unit's results are buffered in a 2-entry FIFO and drained into idle write slots. A wait counter forces a one-cycle pipeline bubble when the buffered result has waited too long.

---
 rtl/wb_port_arbiter.sv | 83 ++++++++
 tb/tb_wb_port_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between pipeline writeback and a 2-entry long-latency result FIFO
// Ports: clk/rst_n (async active-low); p_* pipeline writeback; l_*/l_ready long-latency offer;
// pipe_stall forces a writeback bubble; rf_* registered write port; lq_count FIFO fill; err_drop sticky drop flag.
module wb_port_arbiter #(
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p_valid,
  input  logic [4:0]  p_rd,
  input  logic [31:0] p_data,
  input  logic        l_valid,
  input  logic [4:0]  l_rd,
  input  logic [31:0] l_data,
  output logic        l_ready,
  output logic        pipe_stall,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [1:0]  lq_count,
  output logic        err_drop
);
  typedef enum logic [1:0] {G_IDLE, G_P, G_L, G_FORCE} grant_t;
  logic [4:0]  r_rd [2];
  logic [31:0] r_data [2];
  logic        r_wptr, r_rptr, r_err, r_we;
  logic [1:0]  r_count;
  logic [3:0]  r_wait;
  logic [4:0]  r_waddr;
  logic [31:0] r_wdata;
  logic        w_nonempty, w_push, w_pop;
  logic [4:0]  w_rd;
  logic [31:0] w_data;
  grant_t      w_grant;
  assign w_nonempty = r_count != 2'd0;
  assign l_ready    = r_count != 2'd2;
  assign pipe_stall = (r_wait == 4'(MAX_WAIT)) && w_nonempty;
  assign w_push     = l_valid && l_ready;
  always_comb begin
    w_grant = G_IDLE;
    if (pipe_stall) w_grant = G_FORCE;
    else if (p_valid) w_grant = G_P;
    else if (w_nonempty) w_grant = G_L;
  end
  assign w_pop  = (w_grant == G_FORCE) || (w_grant == G_L);
  assign w_rd   = w_pop ? r_rd[r_rptr] : p_rd;
  assign w_data = w_pop ? r_data[r_rptr] : p_data;
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_rd[r_wptr]   <= l_rd;
      r_data[r_wptr] <= l_data;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
      r_wait  <= 4'd0;
      r_err   <= 1'b0;
      r_we    <= 1'b0;
      r_waddr <= 5'd0;
      r_wdata <= 32'd0;
    end else begin
      r_wptr  <= r_wptr ^ w_push;
      r_rptr  <= r_rptr ^ w_pop;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      r_wait  <= (w_pop || !w_nonempty) ? 4'd0 : (w_grant == G_P) ? r_wait + 4'd1 : r_wait;
      r_err   <= r_err || ((w_grant == G_FORCE) && p_valid);
      // A grant to x0 still consumes the slot but never writes
      r_we    <= (w_grant != G_IDLE) && (w_rd != 5'd0);
      if (w_grant != G_IDLE) begin
        r_waddr <= w_rd;
        r_wdata <= w_data;
      end
    end
  end
  assign rf_we    = r_we;
  assign rf_waddr = r_waddr;
  assign rf_wdata = r_wdata;
  assign lq_count = r_count;
  assign err_drop = r_err;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: scoreboard bench for wb_port_arbiter with directed vectors
module tb_wb_port_arbiter;
  logic        clk, rst_n;
  logic        p_valid, l_valid;
  logic [4:0]  p_rd, l_rd;
  logic [31:0] p_data, l_data;
  logic        l_ready, pipe_stall, rf_we, err_drop;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [1:0]  lq_count;
  int total = 0;
  int bad = 0;
  logic [36:0] exp_q [$];
  logic [4:0]  fl_rd [3];
  logic [31:0] fl_data [3];

  wb_port_arbiter #(.MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .p_valid(p_valid), .p_rd(p_rd), .p_data(p_data),
    .l_valid(l_valid), .l_rd(l_rd), .l_data(l_data),
    .l_ready(l_ready), .pipe_stall(pipe_stall),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .lq_count(lq_count), .err_drop(err_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && rf_we) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL write_unexpected got=%0d:%h expected none", rf_waddr, rf_wdata);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        if ({rf_waddr, rf_wdata} !== e) begin
          bad++;
          $display("FAIL write got=%0d:%h expected=%0d:%h", rf_waddr, rf_wdata, e[36:32], e[31:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic acc;
    int idx;
    rst_n = 1'b0; p_valid = 0; p_rd = 0; p_data = 0; l_valid = 0; l_rd = 0; l_data = 0;
    fl_rd[0] = 5'd10; fl_data[0] = 32'hA0A0;
    fl_rd[1] = 5'd11; fl_data[1] = 32'hB1B1;
    fl_rd[2] = 5'd12; fl_data[2] = 32'hC2C2;
    cyc(); cyc();
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_waddr", 32'(rf_waddr), 32'd0);
    chk("rst_wdata", rf_wdata, 32'd0);
    chk("rst_lq_count", 32'(lq_count), 32'd0);
    chk("rst_l_ready", 32'(l_ready), 32'd1);
    chk("rst_stall", 32'(pipe_stall), 32'd0);
    chk("rst_err", 32'(err_drop), 32'd0);
    rst_n = 1'b1;
    cyc();
    // pipeline only, then x0
    p_valid = 1; p_rd = 5; p_data = 32'hDEADBEEF;
    exp_q.push_back({5'd5, 32'hDEADBEEF});
    cyc();
    chk("pipe_we", 32'(rf_we), 32'd1);
    p_rd = 0; p_data = 32'h5555;
    cyc();
    chk("pipe_x0_we", 32'(rf_we), 32'd0);
    p_valid = 0;
    cyc();
    // idle drain
    l_valid = 1; l_rd = 9; l_data = 32'h1234;
    exp_q.push_back({5'd9, 32'h1234});
    cyc();
    l_valid = 0;
    chk("drain_count1", 32'(lq_count), 32'd1);
    cyc();
    chk("drain_we", 32'(rf_we), 32'd1);
    chk("drain_count0", 32'(lq_count), 32'd0);
    cyc();
    // starvation with MAX_WAIT=4
    chk("starve_err0", 32'(err_drop), 32'd0);
    l_valid = 1; l_rd = 7; l_data = 32'hAAAA;
    p_valid = 1; p_rd = 1;
    for (int k = 0; k < 5; k++) begin
      p_data = 32'h100 + 32'(k);
      chk("starve_nostall", 32'(pipe_stall), 32'd0);
      exp_q.push_back({5'd1, p_data});
      cyc();
      l_valid = 0;
    end
    chk("starve_stall", 32'(pipe_stall), 32'd1);
    p_data = 32'hBAD;
    exp_q.push_back({5'd7, 32'hAAAA});
    cyc();
    chk("starve_err1", 32'(err_drop), 32'd1);
    chk("starve_count", 32'(lq_count), 32'd0);
    chk("starve_stall_off", 32'(pipe_stall), 32'd0);
    p_valid = 0;
    cyc();
    chk("err_sticky", 32'(err_drop), 32'd1);
    // full FIFO with a hazard unit that honours pipe_stall
    idx = 0;
    l_valid = 1; l_rd = fl_rd[0]; l_data = fl_data[0];
    p_rd = 2;
    for (int k = 0; k < 7; k++) begin
      p_valid = (k != 5);
      p_data = 32'h200 + 32'(k);
      if (k == 2) begin
        chk("full_l_ready", 32'(l_ready), 32'd0);
        chk("full_count", 32'(lq_count), 32'd2);
      end
      if (k == 5) begin
        chk("full_stall", 32'(pipe_stall), 32'd1);
        chk("full_ready_pop_cycle", 32'(l_ready), 32'd0);
      end
      if (k == 6) chk("full_ready_back", 32'(l_ready), 32'd1);
      if (k != 5) exp_q.push_back({5'd2, p_data});
      else exp_q.push_back({fl_rd[0], fl_data[0]});
      acc = l_valid && l_ready;
      cyc();
      if (acc) idx++;
      l_valid = idx < 3;
      if (idx < 3) begin
        l_rd = fl_rd[idx];
        l_data = fl_data[idx];
      end
    end
    chk("full_all_accepted", 32'(idx), 32'd3);
    p_valid = 0;
    exp_q.push_back({fl_rd[1], fl_data[1]});
    exp_q.push_back({fl_rd[2], fl_data[2]});
    cyc(); cyc();
    chk("full_drained", 32'(lq_count), 32'd0);
    // simultaneous push and pop
    l_valid = 1; l_rd = 13; l_data = 32'hD0D0;
    exp_q.push_back({5'd13, 32'hD0D0});
    cyc();
    chk("pp_count_pre", 32'(lq_count), 32'd1);
    l_rd = 14; l_data = 32'hE0E0;
    exp_q.push_back({5'd14, 32'hE0E0});
    cyc();
    l_valid = 0;
    chk("pp_count_same", 32'(lq_count), 32'd1);
    chk("pp_first_addr", 32'(rf_waddr), 32'd13);
    cyc();
    chk("pp_second_addr", 32'(rf_waddr), 32'd14);
    chk("pp_count_empty", 32'(lq_count), 32'd0);
    cyc();
    // asynchronous reset with two buffered entries
    p_valid = 1; p_rd = 3; p_data = 32'h300;
    l_valid = 1; l_rd = 20; l_data = 32'hF0;
    exp_q.push_back({5'd3, 32'h300});
    cyc();
    l_rd = 21; l_data = 32'hF1; p_data = 32'h301;
    exp_q.push_back({5'd3, 32'h301});
    cyc();
    l_valid = 0; p_data = 32'h302;
    chk("pre_rst_count", 32'(lq_count), 32'd2);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_rf_we", 32'(rf_we), 32'd0);
    chk("arst_count", 32'(lq_count), 32'd0);
    chk("arst_l_ready", 32'(l_ready), 32'd1);
    chk("arst_stall", 32'(pipe_stall), 32'd0);
    chk("arst_err", 32'(err_drop), 32'd0);
    p_valid = 0;
    cyc();
    rst_n = 1'b1;
    cyc(); cyc();
    chk("post_rst_count", 32'(lq_count), 32'd0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
